// File: rtl/inv_key_schedule.sv
// AES-128 round-key sequencer: expands the cipher key forward, then walks it back out as round keys 10..0.
// Latency: first key (round 10) valid 10 cycles after start; then one key per cycle; start-to-idle 21 cycles unstalled.
// Backpressure: o_valid is a pure state decode; keys and round hold while i_ready=0, no combinational i_ready->o_valid path.
module inv_key_schedule #(
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_key0,
    input  logic [DATA_WIDTH-1:0] i_key1,
    input  logic [DATA_WIDTH-1:0] i_key2,
    input  logic [DATA_WIDTH-1:0] i_key3,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_key0,
    output logic [DATA_WIDTH-1:0] o_key1,
    output logic [DATA_WIDTH-1:0] o_key2,
    output logic [DATA_WIDTH-1:0] o_key3,
    output logic [3:0]            o_round,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon_f(input logic [3:0] r);
        case (r)
            4'd1:    rcon_f = 8'h01;
            4'd2:    rcon_f = 8'h02;
            4'd3:    rcon_f = 8'h04;
            4'd4:    rcon_f = 8'h08;
            4'd5:    rcon_f = 8'h10;
            4'd6:    rcon_f = 8'h20;
            4'd7:    rcon_f = 8'h40;
            4'd8:    rcon_f = 8'h80;
            4'd9:    rcon_f = 8'h1b;
            4'd10:   rcon_f = 8'h36;
            default: rcon_f = 8'h00;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] k0_q, k1_q, k2_q, k3_q;
    logic [DATA_WIDTH-1:0] k0_d, k1_d, k2_d, k3_d;
    logic [3:0]            round_q, round_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] sub_in, rot_w, sub_w, t_w;
    logic [DATA_WIDTH-1:0] fk0, fk1, fk2, fk3;
    logic [3:0]            rcon_idx;

    // Shared S-box datapath: forward uses k3 with Rcon[round+1]; inverse uses the recovered previous k3 with Rcon[round]
    always_comb begin
        sub_in   = (state_q == EMIT) ? (k3_q ^ k2_q) : k3_q;
        rcon_idx = (state_q == EMIT) ? round_q : (round_q + 4'd1);
        rot_w    = {sub_in[23:0], sub_in[31:24]};
        sub_w    = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
        t_w      = sub_w ^ {rcon_f(rcon_idx), {(DATA_WIDTH-8){1'b0}}};
        fk0      = k0_q ^ t_w;
        fk1      = k1_q ^ fk0;
        fk2      = k2_q ^ fk1;
        fk3      = k3_q ^ fk2;
    end

    // Next-state logic: load on start, step forward while expanding, step backward on each accepted key
    always_comb begin
        state_d = state_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    k0_d    = i_key0;
                    k1_d    = i_key1;
                    k2_d    = i_key2;
                    k3_d    = i_key3;
                    round_d = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                k0_d    = fk0;
                k1_d    = fk1;
                k2_d    = fk2;
                k3_d    = fk3;
                round_d = round_q + 4'd1;
                if (round_q == 4'(NR - 1)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (i_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // previous words: k3^k2, k2^k1, k1^k0, and k0 undone through the S-box term
                        k0_d    = k0_q ^ t_w;
                        k1_d    = k1_q ^ k0_q;
                        k2_d    = k2_q ^ k1_q;
                        k3_d    = k3_q ^ k2_q;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, key words, round counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign o_key0  = k0_q;
    assign o_key1  = k1_q;
    assign o_key2  = k2_q;
    assign o_key3  = k3_q;
    assign o_round = round_q;
    assign o_valid = (state_q == EMIT);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;

endmodule
